// File: rtl/raster_dispatch.sv
// Triangle command dispatcher for the z-buffered rasterizer: queues commands, launches them on the
// start/done handshake, runs full-screen z-buffer clears and owns the shared z-buffer write port.
module raster_dispatch #(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 240,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [31:0] CLEAR_VALUE   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_start,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [63:0] i_cmd_v1,
  input  logic [63:0] i_cmd_v2,
  input  logic [63:0] i_cmd_v3,
  input  logic [31:0] i_cmd_iz1,
  input  logic [31:0] i_cmd_iz2,
  input  logic [31:0] i_cmd_iz3,
  output logic        o_tri_start,
  output logic [63:0] o_tri_v1,
  output logic [63:0] o_tri_v2,
  output logic [63:0] o_tri_v3,
  output logic [31:0] o_tri_iz1,
  output logic [31:0] o_tri_iz2,
  output logic [31:0] o_tri_iz3,
  input  logic        i_tri_done,
  input  logic [16:0] i_rast_zb_addr,
  input  logic [31:0] i_rast_zb_data,
  input  logic        i_rast_zb_we,
  output logic [16:0] o_zb_addr,
  output logic [31:0] o_zb_data,
  output logic        o_zb_we,
  output logic        o_busy
);

  localparam int unsigned NUM_PIX   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned ENT_W     = 3 * 64 + 3 * 32;
  localparam logic [16:0] LAST_ADDR = 17'(NUM_PIX - 1);

  // S_SKIP is the cycle after the start pulse, where done may still be high from the idle period.
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LAUNCH, S_START, S_SKIP, S_WAIT} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [ENT_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_clear_pending;
  logic [16:0]        r_clr_cnt;
  logic [ENT_W-1:0]   r_tri;
  logic               w_push;
  logic               w_pop;
  logic               w_clear_last;
  logic               w_enter_clear;

  assign o_cmd_ready   = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push        = i_cmd_valid & o_cmd_ready;
  assign w_pop         = (r_state == S_LAUNCH);
  assign w_clear_last  = (r_state == S_CLEAR) && (r_clr_cnt == LAST_ADDR);
  assign w_enter_clear = (r_state == S_IDLE) && r_clear_pending;

  assign {o_tri_v1, o_tri_v2, o_tri_v3, o_tri_iz1, o_tri_iz2, o_tri_iz3} = r_tri;
  assign o_busy = (r_state != S_IDLE) | r_clear_pending | (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {i_cmd_v1, i_cmd_v2, i_cmd_v3, i_cmd_iz1, i_cmd_iz2, i_cmd_iz3};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_clear_pending <= 1'b0;
      r_clr_cnt       <= '0;
      r_tri           <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_tri    <= r_fifo[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      // A frame start coinciding with clear entry re-arms the flag, so a second clear follows.
      r_clear_pending <= i_frame_start | (r_clear_pending & ~w_enter_clear);
      if (r_state == S_CLEAR) begin
        r_clr_cnt <= w_clear_last ? 17'd0 : r_clr_cnt + 17'd1;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    o_tri_start = 1'b0;
    o_zb_addr   = i_rast_zb_addr;
    o_zb_data   = i_rast_zb_data;
    o_zb_we     = i_rast_zb_we;
    unique case (r_state)
      S_IDLE: begin
        if (r_clear_pending) begin
          w_state_d = S_CLEAR;
        end else if ((r_count != '0) && i_tri_done) begin
          w_state_d = S_LAUNCH;
        end
      end
      S_CLEAR: begin
        o_zb_addr = r_clr_cnt;
        o_zb_data = CLEAR_VALUE;
        o_zb_we   = 1'b1;
        if (w_clear_last) w_state_d = S_IDLE;
      end
      S_LAUNCH: w_state_d = S_START;
      S_START: begin
        o_tri_start = 1'b1;
        w_state_d   = S_SKIP;
      end
      S_SKIP: w_state_d = S_WAIT;
      S_WAIT: begin
        if (i_tri_done) w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_raster_dispatch.sv
// Directed self-checking bench for raster_dispatch with a small rasterizer handshake model.
// A reduced screen keeps clears short while still covering address 1000.
module tb_raster_dispatch;

  localparam int unsigned W    = 64;
  localparam int unsigned H    = 32;
  localparam int unsigned NPIX = W * H;
  localparam logic [31:0] CV   = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_v1, cmd_v2, cmd_v3;
  logic [31:0] cmd_iz1, cmd_iz2, cmd_iz3;
  logic        tri_start;
  logic [63:0] tri_v1, tri_v2, tri_v3;
  logic [31:0] tri_iz1, tri_iz2, tri_iz3;
  logic        tri_done;
  logic [16:0] rz_addr;
  logic [31:0] rz_data;
  logic        rz_we;
  logic [16:0] zb_addr;
  logic [31:0] zb_data;
  logic        zb_we;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  raster_dispatch #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .FIFO_DEPTH   (4),
    .CLEAR_VALUE  (CV)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (frame_start),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_v1      (cmd_v1),
    .i_cmd_v2      (cmd_v2),
    .i_cmd_v3      (cmd_v3),
    .i_cmd_iz1     (cmd_iz1),
    .i_cmd_iz2     (cmd_iz2),
    .i_cmd_iz3     (cmd_iz3),
    .o_tri_start   (tri_start),
    .o_tri_v1      (tri_v1),
    .o_tri_v2      (tri_v2),
    .o_tri_v3      (tri_v3),
    .o_tri_iz1     (tri_iz1),
    .o_tri_iz2     (tri_iz2),
    .o_tri_iz3     (tri_iz3),
    .i_tri_done    (tri_done),
    .i_rast_zb_addr(rz_addr),
    .i_rast_zb_data(rz_data),
    .i_rast_zb_we  (rz_we),
    .o_zb_addr     (zb_addr),
    .o_zb_data     (zb_data),
    .o_zb_we       (zb_we),
    .o_busy        (busy)
  );

  // Rasterizer model: done stays high for one cycle after start, then low for 'hold' cycles.
  int           hold = 50;
  int           stab_err = 0;
  logic [15:0]  rcnt;
  logic         arm;
  logic [287:0] cap;
  logic [63:0]  log_v1[$];
  logic [31:0]  log_iz3[$];

  assign tri_done = (rcnt == 16'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= 16'd0;
      arm  <= 1'b0;
    end else begin
      if (arm) begin
        rcnt <= 16'(hold);
        arm  <= 1'b0;
      end else if (rcnt != 16'd0) begin
        rcnt <= rcnt - 16'd1;
      end
      if ((arm || rcnt != 16'd0) &&
          ({tri_v1, tri_v2, tri_v3, tri_iz1, tri_iz2, tri_iz3} !== cap)) begin
        stab_err <= stab_err + 1;
      end
      if (tri_start) begin
        arm <= 1'b1;
        cap <= {tri_v1, tri_v2, tri_v3, tri_iz1, tri_iz2, tri_iz3};
        log_v1.push_back(tri_v1);
        log_iz3.push_back(tri_iz3);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] mk_v(input int k, input int j);
    return {32'(k * 64 + j), 32'(k * 16 + j * 3 + 1)};
  endfunction

  function automatic logic [31:0] mk_iz(input int k, input int j);
    return 32'((k << 16) + j * 257);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input int bound, output bit ok);
    cmd_v1 = a; cmd_v2 = b; cmd_v3 = c;
    cmd_iz1 = x; cmd_iz2 = y; cmd_iz3 = z;
    cmd_valid = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) step();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic push_k(input int k, input string tag);
    bit ok;
    push(mk_v(k, 1), mk_v(k, 2), mk_v(k, 3), mk_iz(k, 1), mk_iz(k, 2), mk_iz(k, 3), 300, ok);
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (!tri_start && n < 300) begin
      step();
      n++;
    end
    check(tag, tri_start, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic start_clear();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    #1;
    check("pend_busy", busy, 1'b1);
    check("pend_we", zb_we, 1'b0);
    step();
  endtask

  task automatic clear_check(input int unsigned from, input int unsigned cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      if (i != 0) step();
      check($sformatf("clear_%0d", from + i), {zb_we, zb_addr, zb_data},
            {1'b1, 17'(from + i), CV});
    end
  endtask

  initial begin
    int n;
    int base;
    bit ok;
    logic [63:0] sv1, sv2, sv3;
    logic [31:0] siz;

    rst_n = 1'b0; frame_start = 1'b0; cmd_valid = 1'b0;
    cmd_v1 = '0; cmd_v2 = '0; cmd_v3 = '0; cmd_iz1 = '0; cmd_iz2 = '0; cmd_iz3 = '0;
    rz_addr = '0; rz_data = '0; rz_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_we", zb_we, 1'b0);
    check("rst_start", tri_start, 1'b0);
    check("rst_tri_v1", tri_v1, 64'h0);
    check("rst_tri_iz3", tri_iz3, 32'h0);
    rst_n = 1'b1;
    #1;

    // Idle: z-buffer port follows the rasterizer with no latency
    rz_addr = 17'h1ABCD; rz_data = 32'h1234_5678; rz_we = 1'b1;
    #1;
    check("idle_addr", zb_addr, 17'h1ABCD);
    check("idle_data", zb_data, 32'h1234_5678);
    check("idle_we", zb_we, 1'b1);
    rz_we = 1'b0;
    #1;
    check("idle_we0", zb_we, 1'b0);

    // Full clear
    start_clear();
    clear_check(0, NPIX);
    step();
    check("clr_end_we", zb_we, 1'b0);
    check("clr_end_busy", busy, 1'b0);
    check("clr_end_addr", zb_addr, 17'h1ABCD);

    // Single triangle
    base = log_v1.size();
    sv1 = {32'd16 << 4, 32'd16 << 4};
    sv2 = {32'd16 << 4, 32'd160 << 4};
    sv3 = {32'd160 << 4, 32'd16 << 4};
    siz = 32'd65536;
    push(sv1, sv2, sv3, siz, siz, siz, 10, ok);
    check("tri_push", ok, 1'b1);
    check("tri_busy", busy, 1'b1);
    wait_start("tri_start", n);
    check("tri_latency", n, 2);
    check("tri_v1", tri_v1, sv1);
    check("tri_v2", tri_v2, sv2);
    check("tri_v3", tri_v3, sv3);
    check("tri_iz1", tri_iz1, siz);
    check("tri_iz2", tri_iz2, siz);
    check("tri_iz3", tri_iz3, siz);
    step();
    check("tri_start_1cyc", tri_start, 1'b0);
    step();
    rz_addr = 17'h0ABCD; rz_data = 32'hCAFE_F00D; rz_we = 1'b1;
    #1;
    check("wait_zb_addr", zb_addr, 17'h0ABCD);
    check("wait_zb_data", zb_data, 32'hCAFE_F00D);
    check("wait_zb_we", zb_we, 1'b1);
    rz_we = 1'b0;
    wait_idle("tri_idle", 200);
    check("tri_count", log_v1.size() - base, 1);
    check("tri_log_v1", log_v1[base], sv1);

    // FIFO full: A in flight, B..E fill the FIFO, F is stalled until space frees
    base = log_v1.size();
    hold = 60;
    push_k(0, "full_push_0");
    wait_start("full_start_a", n);
    for (int k = 1; k <= 4; k++) push_k(k, $sformatf("full_push_%0d", k));
    check("full_ready0", cmd_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    cmd_v1 = mk_v(5, 1); cmd_v2 = mk_v(5, 2); cmd_v3 = mk_v(5, 3);
    cmd_iz1 = mk_iz(5, 1); cmd_iz2 = mk_iz(5, 2); cmd_iz3 = mk_iz(5, 3);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("full_stall_%0d", i), cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    push_k(5, "full_push_5");
    wait_idle("full_idle", 1000);
    check("full_count", log_v1.size() - base, 6);
    for (int k = 0; k < 6; k++) begin
      if (base + k < log_v1.size()) begin
        check($sformatf("full_order_v1_%0d", k), log_v1[base + k], mk_v(k, 1));
        check($sformatf("full_order_iz3_%0d", k), log_iz3[base + k], mk_iz(k, 3));
      end
    end
    check("full_ready1", cmd_ready, 1'b1);
    check("stable_hold", stab_err, 0);

    // Frame start while a triangle is in flight with two queued behind it
    base = log_v1.size();
    hold = 40;
    push_k(6, "fs_push_6");
    wait_start("fs_start_g", n);
    push_k(7, "fs_push_7");
    push_k(8, "fs_push_8");
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    #1;
    check("fs_busy", busy, 1'b1);
    check("fs_defer_we", zb_we, 1'b0);
    n = 0;
    while (!zb_we && n < 300) begin
      step();
      n++;
    end
    check("fs_clear_seen", zb_we, 1'b1);
    check("fs_done_before", tri_done, 1'b1);
    check("fs_launches_before", log_v1.size() - base, 1);
    clear_check(0, NPIX);
    step();
    check("fs_clr_end_we", zb_we, 1'b0);
    wait_idle("fs_idle", 500);
    check("fs_count", log_v1.size() - base, 3);
    if (log_v1.size() >= base + 3) begin
      check("fs_order_7", log_v1[base + 1], mk_v(7, 1));
      check("fs_order_8", log_v1[base + 2], mk_v(8, 1));
    end

    // Asynchronous reset in the middle of a clear
    start_clear();
    clear_check(0, 1001);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_we", zb_we, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", cmd_ready, 1'b1);
    check("arst_addr", zb_addr, rz_addr);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    start_clear();
    clear_check(0, NPIX);
    step();
    check("arst_clr_end_we", zb_we, 1'b0);
    check("arst_clr_end_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
